// File: rtl/hdmi_i2c_pkg.sv
// Shared types and constants for the HDMI transmitter I2C register writer.
package hdmi_i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        BIT,
        ACK,
        STOP
    } state_t;

    typedef logic [1:0] quarter_t;

    localparam logic [6:0] ADV7513_ADDR = 7'h39;
    localparam int         XFER_BITS    = 29;

endpackage

// File: rtl/i2c_quarter_tick.sv
// Quarter-bit timebase: one-cycle tick every CLK_DIV clocks plus a 2-bit quarter index.
module i2c_quarter_tick
    import hdmi_i2c_pkg::*;
#(
    parameter int CLK_DIV = 125
) (
    input  logic     CLK_50MHZ,
    input  logic     RESET,
    input  logic     clear,
    output logic     tick,
    output quarter_t quarter
);

    logic [9:0] cnt;
    logic       terminal;

    assign terminal = (cnt == 10'(CLK_DIV - 1));
    assign tick     = terminal && !clear;

    always_ff @(posedge CLK_50MHZ) begin
        if (RESET || clear) begin
            cnt     <= '0;
            quarter <= '0;
        end else if (terminal) begin
            cnt     <= '0;
            quarter <= quarter + 2'd1;
        end else begin
            cnt     <= cnt + 10'd1;
        end
    end

endmodule

// File: rtl/i2c_reg_writer.sv
// I2C master that writes one data byte to one device register per request.
// Define I2C_ACK_CHECK_EN to sample ACK slots, flag ERR and stop early on NACK.
//
// state | meaning
// IDLE  | ready for a request, both lines released
// START | SDA falls with SCL high, then SCL pulled low
// BIT   | one data bit MSB first, SCL high in quarters 2-3
// ACK   | SDA released for the device acknowledge
// STOP  | SDA rises with SCL high, DONE on the last quarter
module i2c_reg_writer
    import hdmi_i2c_pkg::*;
#(
    parameter int CLK_DIV = 125
) (
    input  logic       CLK_50MHZ,
    input  logic       RESET,
    input  logic       REQ_VALID,
    output logic       REQ_READY,
    input  logic [6:0] REQ_DEV,
    input  logic [7:0] REQ_REG,
    input  logic [7:0] REQ_DATA,
    output logic       DONE,
    output logic       ERR,
    input  logic       I2C_SCL_RD,
    input  logic       I2C_SDA_RD,
    output logic       I2C_SCL_WR_EN,
    output logic       I2C_SCL_WR_DAT,
    output logic       I2C_SDA_WR_EN,
    output logic       I2C_SDA_WR_DAT
);

    state_t     state, state_n;
    logic       tick, last_quarter, accept, nack_stop;
    quarter_t   quarter;
    logic [7:0] byte_sr, reg_q, data_q;
    logic [2:0] bit_cnt;
    logic [1:0] byte_idx;
    logic       sda_q, scl_low, sda_low;

    assign accept       = REQ_VALID && REQ_READY;
    assign last_quarter = tick && (quarter == 2'd3);
    assign REQ_READY    = (state == IDLE);

    i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .CLK_50MHZ (CLK_50MHZ),
        .RESET     (RESET),
        .clear     (state == IDLE),
        .tick      (tick),
        .quarter   (quarter)
    );

`ifdef I2C_ACK_CHECK_EN
    logic nack_q, err_q, unused_scl;
    assign unused_scl = I2C_SCL_RD;

    always_ff @(posedge CLK_50MHZ) begin
        if (RESET || accept) begin
            nack_q <= 1'b0;
            err_q  <= 1'b0;
        end else if (state == ACK && tick && quarter == 2'd2) begin
            nack_q <= I2C_SDA_RD;
        end else if (state == ACK && last_quarter && nack_q) begin
            err_q  <= 1'b1;
        end
    end

    assign nack_stop = nack_q;
    assign ERR       = err_q;
`else
    logic unused_pads;
    assign unused_pads = I2C_SCL_RD ^ I2C_SDA_RD;
    assign nack_stop   = 1'b0;
    assign ERR         = 1'b0;
`endif

    always_ff @(posedge CLK_50MHZ) begin
        if (RESET) begin
            state    <= IDLE;
            sda_q    <= 1'b0;
            byte_sr  <= '0;
            reg_q    <= '0;
            data_q   <= '0;
            bit_cnt  <= '0;
            byte_idx <= '0;
        end else begin
            state <= state_n;
            sda_q <= sda_low;
            if (accept) begin
                byte_sr  <= {REQ_DEV, 1'b0};
                reg_q    <= REQ_REG;
                data_q   <= REQ_DATA;
                bit_cnt  <= '0;
                byte_idx <= '0;
            end else if (last_quarter && state == BIT) begin
                byte_sr <= {byte_sr[6:0], 1'b0};
                bit_cnt <= bit_cnt + 3'd1;
            end else if (last_quarter && state == ACK) begin
                byte_sr  <= (byte_idx == 2'd0) ? reg_q : data_q;
                byte_idx <= byte_idx + 2'd1;
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:  if (REQ_VALID) state_n = START;
            START: if (last_quarter) state_n = BIT;
            BIT:   if (last_quarter && bit_cnt == 3'd7) state_n = ACK;
            ACK:   if (last_quarter) state_n = (byte_idx == 2'd2 || nack_stop) ? STOP : BIT;
            STOP:  if (last_quarter) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // SDA holds its previous level through quarter 0 so it only moves after SCL is low.
    always_comb begin
        scl_low = 1'b0;
        sda_low = 1'b0;
        DONE    = 1'b0;
        case (state)
            START: begin
                scl_low = quarter[1];
                sda_low = (quarter != 2'd0);
            end
            BIT: begin
                scl_low = ~quarter[1];
                sda_low = (quarter == 2'd0) ? sda_q : ~byte_sr[7];
            end
            ACK: begin
                scl_low = ~quarter[1];
                sda_low = (quarter == 2'd0) ? sda_q : 1'b0;
            end
            STOP: begin
                scl_low = ~quarter[1];
                sda_low = (quarter == 2'd0) ? sda_q : (quarter != 2'd3);
                DONE    = last_quarter;
            end
            default: ;
        endcase
    end

    assign I2C_SCL_WR_EN  = scl_low;
    assign I2C_SDA_WR_EN  = sda_low;
    assign I2C_SCL_WR_DAT = 1'b0;
    assign I2C_SDA_WR_DAT = 1'b0;

endmodule

// File: tb/tb_i2c_reg_writer.sv
// Scoreboard bench for i2c_reg_writer: expectations queued at issue, checked on DONE.
module tb_i2c_reg_writer;
    import hdmi_i2c_pkg::*;

    localparam int CLK_DIV    = 4;
    localparam int PERIOD_CYC = 4 * CLK_DIV;
`ifdef I2C_ACK_CHECK_EN
    localparam bit ACK_CHECK = 1'b1;
`else
    localparam bit ACK_CHECK = 1'b0;
`endif

    typedef struct {
        logic [31:0] bits;
        int          nbits;
        int          latency;
        logic        err;
    } exp_t;

    exp_t exp_q[$];

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [6:0] req_dev = '0;
    logic [7:0] req_reg = '0;
    logic [7:0] req_data = '0;
    logic       done, err;
    logic       scl_en, scl_dat, sda_en, sda_dat, scl_rd, sda_rd;
    logic       slave_pull = 1'b0;

    int checks = 0, failures = 0;
    int cyc = 0, acc_cyc = 0, acc_count = 0, done_count = 0, last_done_cyc = -1000;
    int nack_slot = -1;
    bit xfer_active = 1'b0, check_b2b = 1'b0, ready_bad = 1'b0;
    int n_start = 0, n_stop = 0, n_cap = 0;
    logic [31:0] cap = '0;
    logic scl_prev = 1'b1, sda_prev = 1'b1;

    always #5 clk = ~clk;

    assign scl_rd = ~scl_en;
    assign sda_rd = ~sda_en & ~slave_pull;

    i2c_reg_writer #(.CLK_DIV(CLK_DIV)) dut (
        .CLK_50MHZ      (clk),
        .RESET          (rst),
        .REQ_VALID      (req_valid),
        .REQ_READY      (req_ready),
        .REQ_DEV        (req_dev),
        .REQ_REG        (req_reg),
        .REQ_DATA       (req_data),
        .DONE           (done),
        .ERR            (err),
        .I2C_SCL_RD     (scl_rd),
        .I2C_SDA_RD     (sda_rd),
        .I2C_SCL_WR_EN  (scl_en),
        .I2C_SCL_WR_DAT (scl_dat),
        .I2C_SDA_WR_EN  (sda_en),
        .I2C_SDA_WR_DAT (sda_dat)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Device model: acknowledges in bit periods 9, 18 and 27 unless that slot is the chosen NACK.
    function automatic bit pull_for(input int c);
        int p;
        if (!xfer_active || c <= acc_cyc) return 1'b0;
        p = (c - acc_cyc - 1) / PERIOD_CYC;
        return (p == 9 || p == 18 || p == 27) && ((p / 9 - 1) != nack_slot);
    endfunction

    always @(posedge clk) begin
        cyc        <= cyc + 1;
        slave_pull <= pull_for(cyc + 1);
    end

    function automatic exp_t build(input logic [6:0] d, input logic [7:0] r,
                                   input logic [7:0] v, input int nack);
        exp_t       e;
        logic [7:0] b [3];
        int         nb;
        b[0] = {d, 1'b0};
        b[1] = r;
        b[2] = v;
        nb = 3;
        if (ACK_CHECK && nack >= 0) nb = nack + 1;
        e.bits  = '0;
        e.nbits = 0;
        for (int i = 0; i < nb; i++) begin
            for (int j = 7; j >= 0; j--) begin
                e.bits = {e.bits[30:0], b[i][j]};
                e.nbits++;
            end
            e.bits = {e.bits[30:0], (i == nack)};
            e.nbits++;
        end
        // SDA is low when SCL rises inside STOP
        e.bits = {e.bits[30:0], 1'b0};
        e.nbits++;
        e.err     = ACK_CHECK && (nack >= 0);
        e.latency = (nb == 3) ? XFER_BITS * PERIOD_CYC : (2 + 9 * nb) * PERIOD_CYC;
        return e;
    endfunction

    always @(negedge clk) begin
        logic scl_l, sda_l;
        exp_t e;
        scl_l = ~scl_en;
        sda_l = sda_rd;
        if (rst) xfer_active = 1'b0;
        if (scl_prev && scl_l && (sda_prev != sda_l)) begin
            if (!sda_l) n_start++;
            else        n_stop++;
        end
        if (!scl_prev && scl_l) begin
            cap = {cap[30:0], sda_l};
            n_cap++;
        end
        if (xfer_active && req_ready) ready_bad = 1'b1;
        if (done) begin
            done_count++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 required=0 cyc=%0d", cyc);
            end else begin
                e = exp_q.pop_front();
                chk("done_latency", cyc - acc_cyc, e.latency);
                chk("err_at_done", 32'(err), 32'(e.err));
                chk("bit_count", n_cap, e.nbits);
                chk("sda_bits", cap, e.bits);
                chk("start_count", n_start, 1);
                chk("stop_count", n_stop, 1);
                chk("ready_low_in_xfer", 32'(ready_bad), 32'd0);
            end
            xfer_active   = 1'b0;
            last_done_cyc = cyc;
        end
        if (req_valid && req_ready && !rst) begin
            if (check_b2b) chk("b2b_accept_cycle", cyc, last_done_cyc + 1);
            acc_cyc     = cyc;
            acc_count++;
            xfer_active = 1'b1;
            ready_bad   = 1'b0;
            n_start     = 0;
            n_stop      = 0;
            n_cap       = 0;
            cap         = '0;
        end
        scl_prev = scl_l;
        sda_prev = sda_l;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [6:0] d, input logic [7:0] r, input logic [7:0] v,
                         input int nack, input bit expect_done);
        int start_acc, guard;
        if (expect_done) exp_q.push_back(build(d, r, v, nack));
        nack_slot = nack;
        start_acc = acc_count;
        req_dev   = d;
        req_reg   = r;
        req_data  = v;
        req_valid = 1'b1;
        guard     = 0;
        while (acc_count == start_acc && guard < 3000) begin
            step(1);
            guard++;
        end
        if (acc_count == start_acc) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=no_accept required=accept dev=0x%0h", d);
        end
    endtask

    task automatic release_req();
        req_valid = 1'b0;
        req_dev   = ~req_dev;
        req_reg   = ~req_reg;
        req_data  = ~req_data;
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 3000) begin
            step(1);
            guard++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=pending%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        int done_before;
        step(3);
        @(negedge clk);
        chk("reset_ready", 32'(req_ready), 32'd1);
        chk("reset_scl_en", 32'(scl_en), 32'd0);
        chk("reset_sda_en", 32'(sda_en), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("wr_dat_low", 32'({scl_dat, sda_dat}), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        step(2);

        issue(ADV7513_ADDR, 8'h41, 8'h10, -1, 1'b1);
        release_req();
        drain();

        issue(7'h50, 8'hA5, 8'h3C, 1, 1'b1);
        release_req();
        drain();
        step(5);
        @(negedge clk);
        chk("err_held_idle", 32'(err), 32'(ACK_CHECK));
        step(1);

        issue(7'h1F, 8'h00, 8'hFF, 0, 1'b1);
        release_req();
        drain();

        issue(7'h2A, 8'h5A, 8'hC3, -1, 1'b1);
        check_b2b = 1'b1;
        issue(7'h7F, 8'hFF, 8'h01, -1, 1'b1);
        check_b2b = 1'b0;
        release_req();
        drain();

        issue(7'h39, 8'h99, 8'h66, -1, 1'b0);
        release_req();
        while (cyc < acc_cyc + 100) step(1);
        done_before = done_count;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_scl_en", 32'(scl_en), 32'd0);
        chk("rst_mid_sda_en", 32'(sda_en), 32'd0);
        chk("rst_mid_ready", 32'(req_ready), 32'd1);
        step(600);
        chk("rst_mid_no_done", done_count, done_before);

        issue(7'h39, 8'h00, 8'h80, -1, 1'b1);
        release_req();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
